hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
Iterative radix-2 restoring divider for the MIPS DIV/DIVU instructions, the sequential counterpart to the combinational add/sub/slt datapath. It accepts one operand pair from the execute stage under a start/busy/done handshake. After 32 iterations plus sign fix-up it writes quotient to LO and remainder to HI. The HI/LO outputs feed MFHI/MFLO.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request division; sampled only in IDLE
signed_op  input  1  1 = DIV (two's complement), 0 = DIVU
A  input  WIDTH  dividend
B  input  WIDTH  divisor
busy  output  1  high in CALC and FIX states
done  output  1  one-cycle pulse; hi/lo valid from this cycle
hi  output  WIDTH  remainder register
lo  output  WIDTH  quotient register
div_by_zero  output  1  set with done when B==0; held until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, internal counters/shift regs=0. Reset mid-operation aborts immediately. No partial result reaches hi/lo.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 at edge E0 latches A, B and signed_op. It clears div_by_zero.
  - If B==0: go to DONE. Write lo=all-ones, hi=A, div_by_zero=1.
  - Otherwise: load |A| into the quotient shift register and |B| into the divisor register. Zero the partial remainder. Set count=WIDTH-1. Go to CALC.
- Magnitudes: when signed_op=1 and the MSB is set, negate the operand (two's complement). 0x80000000 is kept as unsigned 0x80000000. When signed_op=0, operands are used as-is.
- CALC: one iteration per clock.
  - Shift {rem,quo} left by 1.
  - Compute trial = rem - divisor with a WIDTH+1-bit subtract.
  - If trial is non-negative: rem=trial, quo LSB=1. Otherwise quo LSB=0.
  - When count==0, go to FIX; otherwise decrement count. CALC occupies edges E1..E32.
- FIX (edge E33): q_neg = signed_op & (A_msb ^ B_msb); r_neg = signed_op & A_msb.
  - lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency: done is high in the cycle after E33, i.e. 34 cycles after the start edge. For divide-by-zero, done is high in the cycle after E0.
- Signed overflow 0x80000000 / 0xFFFFFFFF falls out naturally as lo=0x80000000, hi=0. No trap is raised.
- start is ignored in CALC, FIX and DONE; it is not queued. A and B may change freely after E0.
- hi/lo hold their previous values throughout CALC and FIX, and change only at FIX or the divide-by-zero edge.
- start asserted in the same cycle as done is ignored. The next accept is possible one cycle later, in IDLE.
- All outputs are registered.

Test Plan:
- DIVU: A=100, B=7 -> done exactly 34 cycles after start; lo=14, hi=2; busy high for cycles 1..33; div_by_zero=0.
- DIV: A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also A=7, B=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Divide by zero: A=5, B=0 -> done one cycle after start; lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following valid start clears div_by_zero.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Unsigned 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
  - Unsigned 3 / 0xFFFFFFFF -> lo=0, hi=3.
- Handshake:
  - Pulse start again at cycle 10 with different operands -> ignored; result matches the first operands.
  - start held high through done -> second division is accepted the cycle after done.
- Reset mid-op: drop rst_n at cycle 15 of CALC -> busy/done/hi/lo/div_by_zero are 0 asynchronously. A new division after release completes correctly in 34 cycles.

Source files
------------

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient lands in lo, remainder in hi; divide-by-zero short-circuits to DONE.
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] rem, quo, dvs, a_mag, b_mag;
    logic [WIDTH:0] rem_sh, trial;
    logic [CW-1:0] count;
    logic q_neg, r_neg, b_zero;

    always_comb begin
        b_zero = B == '0;
        a_mag = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag = (signed_op && B[WIDTH-1]) ? -B : B;
        rem_sh = {rem, quo[WIDTH-1]};
        // rem < dvs always holds, so the trial fits WIDTH+1 bits and its MSB is the sign
        trial = rem_sh - {1'b0, dvs};
        state_nx = state == IDLE ? (start ? (b_zero ? DONE : CALC) : IDLE) :
                   state == CALC ? (count == '0 ? FIX : CALC) :
                   state == FIX  ? DONE : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
            div_by_zero <= 1'b0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            count <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            busy <= state_nx == CALC || state_nx == FIX;
            done <= state_nx == DONE;
            case (state)
                IDLE: if (start) begin
                    div_by_zero <= b_zero;
                    q_neg <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                    r_neg <= signed_op & A[WIDTH-1];
                    if (b_zero) begin
                        lo <= '1;
                        hi <= A;
                    end else begin
                        quo <= a_mag;
                        dvs <= b_mag;
                        rem <= '0;
                        count <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count - CW'(1);
                end
                FIX: begin
                    lo <= q_neg ? -quo : quo;
                    hi <= r_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: table vectors, randomized ops against an arithmetic model, and handshake/reset sequences.
module tb_hilo_div_unit;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int total = 0, passed = 0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s;
        logic [31:0] a, b, lo, hi;
        logic dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mlo, output logic [31:0] mhi, output logic mdz);
        longint x, y, q, r;
        if (b == 0) begin
            mlo = '1;
            mhi = a;
            mdz = 1'b1;
        end else begin
            x = s ? longint'($signed(a)) : longint'({32'b0, a});
            y = s ? longint'($signed(b)) : longint'({32'b0, b});
            q = x / y;
            r = x % y;
            mlo = q[31:0];
            mhi = r[31:0];
            mdz = 1'b0;
        end
    endfunction

    // Issues one op, scrambles operands after acceptance, returns results and cycles until done.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rlo, output logic [31:0] rhi, output logic rdz,
                           output int n, output logic busy_ok);
        @(negedge clk);
        start = 1'b1;
        signed_op = s;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        signed_op = ~s;
        n = 0;
        busy_ok = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        rlo = lo;
        rhi = hi;
        rdz = div_by_zero;
    endtask

    task automatic check_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
        logic [31:0] rlo, rhi;
        logic rdz, bok;
        int n;
        run_div(s, a, b, rlo, rhi, rdz, n, bok);
        chk({nm, " lo"}, rlo, elo);
        chk({nm, " hi"}, rhi, ehi);
        chk({nm, " dz"}, rdz, edz);
        chk({nm, " latency"}, n, b == 0 ? 1 : 34);
        if (b != 0) chk({nm, " busy"}, bok, 1'b1);
        chk({nm, " busy at done"}, busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[8];
        logic [31:0] mlo, mhi, ra, rb;
        logic mdz, rs;
        int n;
        vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
        vecs[3] = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
        vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[6] = '{1'b0, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd3, 1'b0};
        vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0};

        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset dz", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) check_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                                             vecs[i].lo, vecs[i].hi, vecs[i].dz);
        @(negedge clk);
        chk("done pulse one cycle", done, 1'b0);

        // div_by_zero holds after done, then clears on the next accepted start
        check_op("dz seq div0", 1'b1, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b1);
        repeat (3) @(negedge clk);
        chk("dz held", div_by_zero, 1'b1);
        start = 1'b1; signed_op = 1'b0; A = 32'd9; B = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("dz cleared on start", div_by_zero, 1'b0);
        n = 1;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("dz seq latency", n, 34);
        chk("dz seq lo", lo, 32'd2);

        // second start mid-calculation is ignored; hi/lo hold old values during CALC
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; A = 32'd100; B = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                chk("hold lo in calc", lo, 32'd2);
                chk("hold hi in calc", hi, 32'd1);
                start = 1'b1; A = 32'd1000; B = 32'd3;
                @(negedge clk); n++;
                start = 1'b0;
            end
        end
        chk("ignored start latency", n, 34);
        chk("ignored start lo", lo, 32'd14);
        chk("ignored start hi", hi, 32'd2);

        // start held high across done: next op accepted the cycle after done
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; A = 32'd100; B = 32'd7;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("held start first latency", n, 34);
        A = 32'd50; B = 32'd4;
        @(negedge clk);
        chk("held start idle gap", busy, 1'b0);
        @(negedge clk);
        chk("held start accepted", busy, 1'b1);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("held start second latency", n, 34);
        chk("held start lo", lo, 32'd12);
        chk("held start hi", hi, 32'd2);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; signed_op = 1'b1; A = 32'hFFFFFF00; B = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre-reset busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", busy, 1'b0);
        chk("async rst done", done, 1'b0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        chk("async rst dz", div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_op("post reset", 1'b1, 32'hFFFFFF00, 32'd3, 32'hFFFFFFAB, 32'hFFFFFFFF, 1'b0);

        for (int i = 0; i < 150; i++) begin
            int mode;
            mode = $urandom_range(0, 9);
            rs = $urandom_range(0, 1);
            ra = mode[0] ? $urandom : $urandom_range(0, 5000);
            rb = mode == 0 ? 32'd0 : mode < 5 ? $urandom_range(1, 255) : $urandom;
            if (rs && mode == 2) rb = -rb;
            if (rs && mode == 3) ra = -ra;
            model(rs, ra, rb, mlo, mhi, mdz);
            check_op($sformatf("rand%0d", i), rs, ra, rb, mlo, mhi, mdz);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
